dma_snd_fetch: RTL and testbench

DMA_SND_FETCH -- requirements
Module: dma_snd_fetch

---
 rtl/dma_snd_fetch_pkg.sv | 34 +++
 rtl/dma_snd_fetch_if.sv | 31 +++
 rtl/sync_fifo8.sv | 63 ++++++
 rtl/dma_snd_fetch.sv | 149 ++++++++++++++
 tb/tb_dma_snd_fetch.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_snd_fetch_pkg.sv
// Shared definitions for the dma_* client family.
// Holds the fetch FSM encoding, FIFO geometry, register indices and the
// small helpers used to build the block-length and status values.
package dma_snd_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dma_state_t;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned FIFO_AW    = 3;
    localparam int unsigned ADDR_W     = 22;
    localparam int unsigned LEN_W      = 17;   // up to 256 blocks of 256 bytes

    localparam logic [1:0] REG_ADDR_LO  = 2'd0;
    localparam logic [1:0] REG_ADDR_MID = 2'd1;
    localparam logic [1:0] REG_ADDR_HI  = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    // Transfer length in bytes for a control-register write of 'blocks'.
    function automatic logic [LEN_W-1:0] block_len(input logic [7:0] blocks);
        return {({1'b0, blocks} + 9'd1), 8'h00};
    endfunction

    function automatic logic [7:0] status_byte(input logic       busy,
                                               input logic       empty,
                                               input logic       full,
                                               input logic [3:0] count);
        return {busy, empty, full, 1'b0, count};
    endfunction

endpackage

// File: rtl/dma_snd_fetch_if.sv
// DMA sequencer bus (slot 3) between a fetch client and the sequencer.
//   dma_req  : client requests a read
//   dma_ack  : one-cycle, request accepted (address consumed)
//   dma_end  : one-cycle, dma_rd carries the read data
//   dma_rnw  : read/not-write
//   dma_rd   : read data
//   dma_wd   : write data
//   dma_addr : 22-bit byte address
// master = fetch client side, slave = sequencer side.
interface dma_snd_fetch_if;
    import dma_snd_fetch_pkg::*;

    logic              dma_req;
    logic              dma_ack;
    logic              dma_end;
    logic              dma_rnw;
    logic [7:0]        dma_rd;
    logic [7:0]        dma_wd;
    logic [ADDR_W-1:0] dma_addr;

    modport master (
        output dma_req, dma_rnw, dma_wd, dma_addr,
        input  dma_ack, dma_end, dma_rd
    );

    modport slave (
        input  dma_req, dma_rnw, dma_wd, dma_addr,
        output dma_ack, dma_end, dma_rd
    );

endinterface

// File: rtl/sync_fifo8.sv
// 8-entry x 8-bit synchronous FIFO with first-word-fall-through output.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full and not popping)
//   push_data  : write data
//   pop        : remove head entry (ignored when empty)
//   data       : head entry, 0 while empty
//   count      : occupancy 0..8
//   empty/full : occupancy flags
module sync_fifo8
    import dma_snd_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] data,
    output logic [3:0] count,
    output logic       empty,
    output logic       full
);

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == 4'd0);
    assign full    = (count == 4'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage carries no reset; the output is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    assign data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dma_snd_fetch.sv
// Sound-data DMA fetch client. Reads a block of (n+1)*256 bytes from a
// programmed 22-bit start address through the DMA sequencer and streams the
// bytes out through an 8-entry FIFO.
//   clk, rst_n            : clock, asynchronous active-low reset
//   module_select,
//   write_strobe, regsel,
//   din, dout             : register port (0..2 address bytes, 3 ctrl/status)
//   dma                   : DMA sequencer bus, master side
//   out_data, out_valid,
//   out_ready             : byte stream to the consumer
//   int_req               : one-cycle pulse when a block has fully arrived
module dma_snd_fetch
    import dma_snd_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             module_select,
    input  logic             write_strobe,
    input  logic [1:0]       regsel,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    dma_snd_fetch_if.master  dma,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             int_req
);

    dma_state_t        state_q;
    dma_state_t        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic [1:0]        inflight_q;

    logic              reg_wr;
    logic              start;
    logic              acked;
    logic              ended;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [3:0]        fifo_count;
    logic [4:0]        credit_use;
    logic              req_c;
    logic              irq_c;

    // Registers are only writable while idle.
    assign reg_wr = module_select && write_strobe && (state_q == ST_IDLE);
    assign start  = reg_wr && (regsel == REG_CTRL);
    assign acked  = dma.dma_ack && (state_q == ST_RUN);
    // Reads abandoned by a reset can still complete later; drop them in IDLE.
    assign ended  = dma.dma_end && (state_q != ST_IDLE);

    assign fifo_pop  = out_ready && !fifo_empty;
    assign out_valid = !fifo_empty;

    // Slots already spoken for: stored bytes plus reads still in flight,
    // less the byte leaving this cycle.
    assign credit_use = 5'(fifo_count) + 5'(inflight_q) - 5'(fifo_pop);

    sync_fifo8 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ended),
        .push_data (dma.dma_rd),
        .pop       (fifo_pop),
        .data      (out_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        irq_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                req_c = (credit_use < 5'(FIFO_DEPTH));
                if (acked && (remain_q == LEN_W'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight_q == 2'd0) begin
                    state_d = ST_IDLE;
                    irq_c   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= '0;
        end else begin
            if (reg_wr) begin
                case (regsel)
                    REG_ADDR_LO:  addr_q[7:0]   <= din;
                    REG_ADDR_MID: addr_q[15:8]  <= din;
                    REG_ADDR_HI:  addr_q[21:16] <= din[5:0];
                    default:      remain_q      <= block_len(din);
                endcase
            end else if (acked) begin
                addr_q   <= addr_q + ADDR_W'(1);
                remain_q <= remain_q - LEN_W'(1);
            end
            case ({acked, ended})
                2'b10:   inflight_q <= inflight_q + 2'd1;
                2'b01:   inflight_q <= inflight_q - 2'd1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    always_comb begin
        dout = '0;
        case (regsel)
            REG_ADDR_LO:  dout = addr_q[7:0];
            REG_ADDR_MID: dout = addr_q[15:8];
            REG_ADDR_HI:  dout = {2'b00, addr_q[21:16]};
            default:      dout = status_byte(state_q != ST_IDLE, fifo_empty,
                                             fifo_full, fifo_count);
        endcase
    end

    assign dma.dma_req  = req_c;
    assign dma.dma_rnw  = 1'b1;
    assign dma.dma_wd   = '0;
    assign dma.dma_addr = addr_q;
    assign int_req      = irq_c;

endmodule

// File: tb/tb_dma_snd_fetch.sv
// Self-checking bench for dma_snd_fetch: a randomized sequencer/consumer
// environment against a transaction-level model of the fetch behaviour.
module tb_dma_snd_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        module_select;
    logic        write_strobe;
    logic [1:0]  regsel;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        int_req;

    dma_snd_fetch_if dma_bus ();

    dma_snd_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .module_select (module_select),
        .write_strobe  (write_strobe),
        .regsel        (regsel),
        .din           (din),
        .dout          (dout),
        .dma           (dma_bus),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .int_req       (int_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [7:0]  data;
    } rd_t;

    rd_t         pend_q[$];     // reads accepted by the sequencer, not yet returned
    logic [7:0]  exp_q[$];      // bytes expected in the FIFO, in order
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    logic [21:0] m_addr = '0;
    int unsigned m_len  = 0;
    int unsigned m_acks = 0;
    bit          m_busy = 1'b0;
    int unsigned irq_seen = 0;
    int unsigned dut_pops = 0;
    int unsigned ready_mode = 1;   // 0 random, 1 always, 2 never
    int unsigned ack_pct = 100;
    bit          junk_en = 1'b0;
    bit          wr_pend = 1'b0;
    logic [1:0]  wr_sel  = '0;
    logic [7:0]  wr_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [21:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
    endfunction

    // One clock cycle of sequencer + consumer + register traffic.
    task automatic step();
        bit          deliver, pop, exp_req, exp_irq, do_ack, wr_now, was_busy;
        int unsigned qn, inflight, due;
        logic [1:0]  sel_now;
        logic [7:0]  din_now;
        @(negedge clk);
        cyc++;
        if (!wr_pend && junk_en && m_busy && $urandom_range(0, 7) == 0) begin
            wr_pend = 1'b1;
            wr_sel  = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
        end
        wr_now  = wr_pend;
        sel_now = wr_sel;
        din_now = wr_data;
        wr_pend = 1'b0;
        module_select = wr_now;
        write_strobe  = wr_now;
        regsel        = wr_now ? sel_now : 2'd3;
        din           = wr_now ? din_now : 8'h00;
        case (ready_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
        deliver = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
        dma_bus.dma_end = deliver;
        dma_bus.dma_rd  = 8'h00;
        if (deliver) dma_bus.dma_rd = pend_q[0].data;
        #1;
        was_busy = m_busy;
        qn       = exp_q.size();
        inflight = pend_q.size();
        pop      = out_ready && (qn != 0);
        exp_req  = m_busy && (m_acks < m_len) && ((qn + inflight - (pop ? 1 : 0)) < 8);
        exp_irq  = m_busy && (m_len != 0) && (m_acks == m_len) && (inflight == 0);
        check("out_valid", out_valid, qn != 0);
        check("dma_req", dma_bus.dma_req, exp_req);
        check("int_req", int_req, exp_irq);
        if (!wr_now) check("status", dout, {m_busy, qn == 0, qn == 8, 1'b0, 4'(qn)});
        if (int_req) irq_seen++;
        if (out_valid && out_ready) dut_pops++;
        if (pop) check("out_data", out_data, exp_q.pop_front());
        do_ack = dma_bus.dma_req && m_busy && (m_acks < m_len) &&
                 ((inflight - (deliver ? 1 : 0)) < 2) && ($urandom_range(1, 100) <= ack_pct);
        if (do_ack) begin
            dma_bus.dma_ack = 1'b1;
            check("dma_addr", dma_bus.dma_addr, m_addr);
            due = cyc + $urandom_range(1, 2);
            if (pend_q.size() != 0 && pend_q[$].due >= due) due = pend_q[$].due + 1;
            pend_q.push_back('{due: due, data: mem_byte(m_addr)});
            m_addr = m_addr + 22'd1;
            m_acks++;
        end
        if (deliver) begin
            if (m_busy) exp_q.push_back(pend_q[0].data);
            void'(pend_q.pop_front());
        end
        if (exp_irq) m_busy = 1'b0;
        if (wr_now && !was_busy) begin
            case (sel_now)
                2'd0: m_addr[7:0]   = din_now;
                2'd1: m_addr[15:8]  = din_now;
                2'd2: m_addr[21:16] = din_now[5:0];
                default: begin
                    m_busy = 1'b1;
                    m_len  = (int'(din_now) + 1) * 256;
                    m_acks = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        dma_bus.dma_ack = 1'b0;
        dma_bus.dma_end = 1'b0;
        module_select   = 1'b0;
        write_strobe    = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] sel, input logic [7:0] data);
        wr_pend = 1'b1;
        wr_sel  = sel;
        wr_data = data;
        step();
    endtask

    task automatic start_xfer(input logic [21:0] a, input logic [7:0] blocks);
        int unsigned n = 0;
        while (pend_q.size() != 0 && n < 20) begin step(); n++; end
        wr_reg(2'd0, a[7:0]);
        wr_reg(2'd1, a[15:8]);
        wr_reg(2'd2, {2'b00, a[21:16]});
        wr_reg(2'd3, blocks);
    endtask

    task automatic run_done(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (m_busy && n < budget) begin step(); n++; end
        while (exp_q.size() != 0 && n < budget) begin step(); n++; end
        check({tag, "_busy"}, dout[7], 1'b0);
        check({tag, "_valid"}, out_valid, 1'b0);
    endtask

    task automatic read_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        @(negedge clk);
        out_ready = 1'b0;
        regsel    = sel;
        #1;
        check(tag, dout, exp);
        regsel = 2'd3;
    endtask

    task automatic check_addr(input string tag, input logic [21:0] a);
        read_reg({tag, "_lo"},  2'd0, a[7:0]);
        read_reg({tag, "_mid"}, 2'd1, a[15:8]);
        read_reg({tag, "_hi"},  2'd2, {2'b00, a[21:16]});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n           = 1'b0;
        dma_bus.dma_ack = 1'b0;
        dma_bus.dma_end = 1'b0;
        out_ready       = 1'b0;
        module_select   = 1'b0;
        write_strobe    = 1'b0;
        regsel          = 2'd3;
        #1;
        check({tag, "_req"},   dma_bus.dma_req, 1'b0);
        check({tag, "_addr"},  dma_bus.dma_addr, 22'h0);
        check({tag, "_irq"},   int_req, 1'b0);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_data"},  out_data, 8'h00);
        check({tag, "_stat"},  dout, 8'h40);
        check({tag, "_rnw"},   dma_bus.dma_rnw, 1'b1);
        check({tag, "_wd"},    dma_bus.dma_wd, 8'h00);
        exp_q.delete();
        m_busy = 1'b0;
        m_addr = '0;
        m_len  = 0;
        m_acks = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned p0, i0, n;
        logic [21:0] a;
        logic [7:0]  b;
        rst_n           = 1'b0;
        module_select   = 1'b0;
        write_strobe    = 1'b0;
        regsel          = 2'd3;
        din             = 8'h00;
        out_ready       = 1'b0;
        dma_bus.dma_ack = 1'b0;
        dma_bus.dma_end = 1'b0;
        dma_bus.dma_rd  = 8'h00;
        repeat (2) @(negedge clk);
        do_reset("rst0");
        check_addr("rst0_a", 22'h0);

        // Basic block, consumer always ready.
        ready_mode = 1; ack_pct = 100;
        p0 = dut_pops; i0 = irq_seen;
        start_xfer(22'h012300, 8'h00);
        run_done("t1", 4000);
        check("t1_pops", dut_pops - p0, 256);
        check("t1_irqs", irq_seen - i0, 1);
        check_addr("t1_a", 22'h012400);

        // Consumer stalled: exactly FIFO_DEPTH reads, then resume.
        ready_mode = 2;
        p0 = dut_pops;
        start_xfer(22'h000200, 8'h00);
        repeat (60) step();
        check("t2_acks", m_acks, 8);
        read_reg("t2_status", 2'd3, 8'hA8);
        ready_mode = 1;
        run_done("t2", 4000);
        check("t2_pops", dut_pops - p0, 256);
        check_addr("t2_a", 22'h000300);

        // Address wrap at the top of the 22-bit space.
        ready_mode = 0; ack_pct = 60;
        p0 = dut_pops; i0 = irq_seen;
        start_xfer(22'h3FFF80, 8'h00);
        run_done("t3", 6000);
        check("t3_pops", dut_pops - p0, 256);
        check("t3_irqs", irq_seen - i0, 1);
        check_addr("t3_a", 22'h000080);

        // Random blocks with ignored register writes during the transfer.
        for (int unsigned k = 0; k < 3; k++) begin
            junk_en = 1'b1;
            ack_pct = $urandom_range(40, 100);
            a = 22'($urandom);
            b = 8'($urandom_range(0, 1));
            p0 = dut_pops; i0 = irq_seen;
            start_xfer(a, b);
            run_done("t4", 8000);
            junk_en = 1'b0;
            check("t4_pops", dut_pops - p0, (int'(b) + 1) * 256);
            check("t4_irqs", irq_seen - i0, 1);
            check_addr("t4_a", a + 22'((int'(b) + 1) * 256));
        end

        // Reset in the middle of a transfer, late read returns, clean restart.
        ready_mode = 0; ack_pct = 100;
        start_xfer(22'h055500, 8'h00);
        n = 0;
        while (m_acks < 100 && n < 2000) begin step(); n++; end
        check("t5_at100", m_acks, 100);
        do_reset("t5_rst");
        repeat (6) step();
        read_reg("t5_idle_stat", 2'd3, 8'h40);
        check_addr("t5_ra", 22'h0);
        ready_mode = 1;
        p0 = dut_pops; i0 = irq_seen;
        start_xfer(22'h000100, 8'h00);
        run_done("t5", 4000);
        check("t5_pops", dut_pops - p0, 256);
        check("t5_irqs", irq_seen - i0, 1);
        check_addr("t5_a", 22'h000200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
